rv_ex_elastic_reg: RTL

//  Elastic pipeline register for the execute->memory boundary. Replaces the fixed

---
 rtl/rv_pipe_pkg.sv | 27 ++
 rtl/rv_ex_elastic_reg_chk.sv | 40 ++++
 rtl/rv_ring_ptr.sv | 30 +++
 rtl/rv_ex_elastic_reg.sv | 108 ++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared execute/memory pipeline types: the payload carried across the
// execute->memory boundary and the default elastic buffer depth.
package rv_pipe_pkg;

    localparam int unsigned EX_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mdu_result;
        logic        mem_req;
        logic        mem_we;
        logic [1:0]  mem_size;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic        gpr_wr_en;
        logic [4:0]  gpr_addr;
        logic [1:0]  gpr_src_sel;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic [31:0] target_pc;
        logic [31:0] next_pc;
        logic        prediction;
        logic        br_j_taken;
    } ex_payload_t;

endpackage

// File: rtl/rv_ex_elastic_reg_chk.sv
// Protocol and occupancy properties for the execute->memory elastic buffer.
module rv_ex_elastic_reg_chk #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 2
) (
    input logic              clk,
    input logic              arstn,
    input logic              flush,
    input logic              push,
    input logic              pop,
    input logic              m_valid,
    input logic              m_ready,
    input logic [DATA_W-1:0] m_data,
    input logic [CNT_W-1:0]  count
);

    int unsigned r_occ;

    // Shadow occupancy built only from accepted transfers
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_occ <= 32'd0;
        end else if (flush) begin
            r_occ <= 32'd0;
        end else begin
            r_occ <= r_occ + 32'(push) - 32'(pop);
        end
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (!arstn)
        (count == CNT_W'(DEPTH)) |-> !push);
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!arstn)
        (count == '0) |-> !pop);
    a_data_hold: assert property (@(posedge clk) disable iff (!arstn)
        (m_valid && !m_ready && !flush) |=> $stable(m_data));
    a_count_match: assert property (@(posedge clk) disable iff (!arstn)
        (32'(count) == r_occ) && (32'(count) <= DEPTH));

endmodule

// File: rtl/rv_ring_ptr.sv
// Ring-buffer index that wraps DEPTH-1 -> 0; DEPTH need not be a power of two.
module rv_ring_ptr #(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] r_ptr;

    // Pointer register: clear has priority over increment
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_ptr <= '0;
        end else if (clr) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + PTR_W'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign ptr_o = r_ptr;

endmodule

// File: rtl/rv_ex_elastic_reg.sv
// Elastic execute->memory register: DEPTH-entry valid/ready ring buffer with
// synchronous flush and optional zero-latency fall-through when empty.
module rv_ex_elastic_reg
    import rv_pipe_pkg::*;
#(
    parameter int unsigned DATA_W       = $bits(ex_payload_t),
    parameter int unsigned DEPTH        = EX_BUF_DEPTH,
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              flush_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              stall_req_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic              w_empty;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;

    // Ready is a pure function of the registered count, so m_ready_i never reaches it
    assign w_empty     = (r_count == '0);
    assign s_ready_o   = (r_count < CNT_W'(DEPTH));
    assign stall_req_o = ~s_ready_o;
    assign count_o     = r_count;

    assign w_bypass = FALL_THROUGH & w_empty & s_valid_i & m_ready_i & ~flush_i;
    assign w_push   = s_valid_i & s_ready_o & ~flush_i & ~w_bypass;
    assign w_pop    = m_valid_o & m_ready_i & ~w_bypass;

    // Output selection: forwarded input when empty in fall-through mode, else head entry
    always_comb begin
        m_valid_o = 1'b0;
        m_data_o  = r_mem[w_rd_ptr];
        if (FALL_THROUGH && w_empty) begin
            m_valid_o = s_valid_i & ~flush_i;
            m_data_o  = s_data_i;
        end else begin
            m_valid_o = ~w_empty & ~flush_i;
            m_data_o  = r_mem[w_rd_ptr];
        end
    end

    // Occupancy counter; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Payload storage is deliberately outside the reset domain
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[w_wr_ptr] <= s_data_i;
        end
    end

    rv_ring_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk_i),
        .arstn (arstn_i),
        .clr   (flush_i),
        .inc   (w_push),
        .ptr_o (w_wr_ptr)
    );

    rv_ring_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk_i),
        .arstn (arstn_i),
        .clr   (flush_i),
        .inc   (w_pop),
        .ptr_o (w_rd_ptr)
    );

    rv_ex_elastic_reg_chk #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
        .clk     (clk_i),
        .arstn   (arstn_i),
        .flush   (flush_i),
        .push    (w_push),
        .pop     (w_pop),
        .m_valid (m_valid_o),
        .m_ready (m_ready_i),
        .m_data  (m_data_o),
        .count   (count_o)
    );

endmodule
